// File: rtl/riscv_wb_pkg.sv
// Shared constants for the write-back slice.
// Holds the register-index width, the default data and counter widths,
// and the x0 index constant used by riscv_wb and riscv_regfile.
package riscv_wb_pkg;

    localparam int                REGW     = 5;   // register index width
    localparam int                XLEN_DEF = 32;  // default data width
    localparam int                CNTW_DEF = 64;  // default instret width
    localparam logic [REGW-1:0]   X0       = '0;  // hardwired-zero register

endpackage

// File: rtl/riscv_regfile.sv
// Integer register file.
// Synchronous clear on rst, one write port, two combinational read ports.
// x0 is never written and always reads 0; indices >= NREGS also read 0.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   we/waddr/wdata   write port (ignored when waddr is x0)
//   raddr1/rdata1    read port 1 (combinational)
//   raddr2/rdata2    read port 2 (combinational)
module riscv_regfile
    import riscv_wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [REGW-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [REGW-1:0] raddr1,
    input  logic [REGW-1:0] raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we && waddr != X0 && int'(waddr) < NREGS) begin
            regs_q[waddr] <= wdata;
        end
    end

    // x0 is forced on the read side as well, so regs_q[0] is never relied upon.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != X0 && int'(raddr1) < NREGS) rdata1 = regs_q[raddr1];
        if (raddr2 != X0 && int'(raddr2) < NREGS) rdata2 = regs_q[raddr2];
    end

endmodule

// File: rtl/riscv_wb.sv
// Write-back stage.
// Registers the MA-stage result {rd, res, valid}, commits it to the register
// file on the following unstalled edge, serves two combinational read ports,
// and counts retired instructions.
// Optional feature: define RISCV_WB_BYPASS_EN to forward the pending wb result
// onto the read ports before it is committed.
// Ports:
//   clk, rst            clock, synchronous active-high reset (beats stall)
//   rdi, resi, validi   result from MA stage
//   stall               hold all state: no capture, commit or count
//   rs1/rs2             read addresses from decode
//   rs1_val/rs2_val     read data, combinational
//   wb_rd/wb_res/wb_valid  pending result awaiting commit
//   instret             retired-instruction count (wraps)
module riscv_wb
    import riscv_wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] rdi,
    input  logic [XLEN-1:0] resi,
    input  logic            validi,
    input  logic            stall,
    input  logic [REGW-1:0] rs1,
    input  logic [REGW-1:0] rs2,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    output logic [REGW-1:0] wb_rd,
    output logic [XLEN-1:0] wb_res,
    output logic            wb_valid,
    output logic [CNTW-1:0] instret
);

    logic [REGW-1:0] wb_rd_q,    wb_rd_d;
    logic [XLEN-1:0] wb_res_q,   wb_res_d;
    logic            wb_valid_q, wb_valid_d;
    logic [CNTW-1:0] instret_q,  instret_d;

    logic            rf_we;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;

    always_comb begin
        wb_rd_d    = wb_rd_q;
        wb_res_d   = wb_res_q;
        wb_valid_d = wb_valid_q;
        instret_d  = instret_q;
        rf_we      = 1'b0;
        if (!stall) begin
            // Bubbles still load rd/res (possibly X); wb_valid gates every use.
            wb_rd_d    = rdi;
            wb_res_d   = resi;
            wb_valid_d = validi;
            if (wb_valid_q) begin
                instret_d = instret_q + CNTW'(1);
                rf_we     = (wb_rd_q != X0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rd_q    <= '0;
            wb_res_q   <= '0;
            wb_valid_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            wb_rd_q    <= wb_rd_d;
            wb_res_q   <= wb_res_d;
            wb_valid_q <= wb_valid_d;
            instret_q  <= instret_d;
        end
    end

    // rst is folded into the regfile's own clear, so a pending result cannot
    // slip in on a reset edge.
    riscv_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (wb_rd_q),
        .wdata  (wb_res_q),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

`ifdef RISCV_WB_BYPASS_EN
    // Forward the uncommitted result; holds through stall since wb_* hold too.
    always_comb begin
        rs1_val = rf_rdata1;
        rs2_val = rf_rdata2;
        if (wb_valid_q && rs1 != X0 && wb_rd_q == rs1) rs1_val = wb_res_q;
        if (wb_valid_q && rs2 != X0 && wb_rd_q == rs2) rs2_val = wb_res_q;
    end
`else
    // Decode sees the old register value until the commit edge.
    assign rs1_val = rf_rdata1;
    assign rs2_val = rf_rdata2;
`endif

    assign wb_rd    = wb_rd_q;
    assign wb_res   = wb_res_q;
    assign wb_valid = wb_valid_q;
    assign instret  = instret_q;

endmodule
